// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-control outputs exchanged between the datapath and pipe_ctrl.
interface pipe_ctrl_if;
  logic [4:0] id_rs, id_rt;
  logic       id_useRt;
  logic       ex_memRead;
  logic [4:0] ex_writeDataReg;
  logic       ex_branchTaken;
  logic       ex_mdStart, ex_mdOp;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       md_busy, md_done;

  modport slave (
    input  id_rs, id_rt, id_useRt, ex_memRead, ex_writeDataReg,
           ex_branchTaken, ex_mdStart, ex_mdOp,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done
  );

  modport master (
    output id_rs, id_rt, id_useRt, ex_memRead, ex_writeDataReg,
           ex_branchTaken, ex_mdStart, ex_mdOp,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, md_busy, md_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stall, taken-branch flush, multi-cycle mul/div freeze.
// Mul/div sequencing is built only when PIPE_CTRL_MULDIV_EN is defined.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave pif
);

  logic load_use;
  logic run_resp;

  assign load_use = pif.ex_memRead && (pif.ex_writeDataReg != 5'd0) &&
                    ((pif.ex_writeDataReg == pif.id_rs) ||
                     (pif.id_useRt && (pif.ex_writeDataReg == pif.id_rt)));

`ifdef PIPE_CTRL_MULDIV_EN
  typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} state_e;

  state_e     state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{pif.ex_mdStart, pif.ex_mdOp, clk};
`endif

  always_comb begin
    pif.pc_en       = 1'b1;
    pif.ifid_en     = 1'b1;
    pif.idex_en     = 1'b1;
    pif.exmem_en    = 1'b1;
    pif.memwb_en    = 1'b1;
    pif.ifid_flush  = 1'b0;
    pif.idex_flush  = 1'b0;
    pif.exmem_flush = 1'b0;
    pif.md_busy     = 1'b0;
    pif.md_done     = 1'b0;
    run_resp        = 1'b0;
`ifdef PIPE_CTRL_MULDIV_EN
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      RUN: begin
        // A starting mul/div owns the cycle; branch/load-use in EX are not acted on.
        if (pif.ex_mdStart) begin
          state_d  = MD_WAIT;
          md_cnt_d = pif.ex_mdOp ? 6'd32 : 6'd4;
        end else begin
          run_resp = 1'b1;
        end
      end
      MD_WAIT: begin
        pif.pc_en       = 1'b0;
        pif.ifid_en     = 1'b0;
        pif.idex_en     = 1'b0;
        pif.exmem_flush = 1'b1;
        pif.md_busy     = 1'b1;
        if (md_cnt_q <= 6'd1) begin
          state_d  = MD_DONE;
          md_cnt_d = 6'd0;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      MD_DONE: begin
        pif.md_done = 1'b1;
        state_d     = RUN;
        md_cnt_d    = 6'd0;
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 6'd0;
      end
    endcase
`else
    run_resp = 1'b1;
`endif
    if (run_resp) begin
      if (pif.ex_branchTaken) begin
        pif.ifid_flush = 1'b1;
        pif.idex_flush = 1'b1;
      end else if (load_use) begin
        // Single-cycle stall: the load moves on to MEM, so the match clears next cycle.
        pif.pc_en      = 1'b0;
        pif.ifid_en    = 1'b0;
        pif.idex_flush = 1'b1;
      end
    end
    if (!rst) begin
      pif.pc_en       = 1'b0;
      pif.ifid_en     = 1'b0;
      pif.idex_en     = 1'b0;
      pif.exmem_en    = 1'b0;
      pif.memwb_en    = 1'b0;
      pif.ifid_flush  = 1'b1;
      pif.idex_flush  = 1'b1;
      pif.exmem_flush = 1'b1;
      pif.md_busy     = 1'b0;
      pif.md_done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected outputs, a monitor checks them.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (.clk(clk), .rst(rst), .pif(pif));

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, md_busy, md_done}
  localparam logic [9:0] E_RST  = 10'b00000_111_00;
  localparam logic [9:0] E_RUN  = 10'b11111_000_00;
  localparam logic [9:0] E_LU   = 10'b00111_010_00;
  localparam logic [9:0] E_BR   = 10'b11111_110_00;
  localparam logic [9:0] E_WAIT = 10'b00011_001_10;
  localparam logic [9:0] E_DONE = 10'b11111_000_01;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    pif.id_rs = '0; pif.id_rt = '0; pif.id_useRt = 1'b0; pif.ex_memRead = 1'b0;
    pif.ex_writeDataReg = '0; pif.ex_branchTaken = 1'b0;
    pif.ex_mdStart = 1'b0; pif.ex_mdOp = 1'b0;
  end

  task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr, input logic [4:0] wr,
                     input logic br, input logic ms, input logic mo,
                     input logic [9:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    pif.id_rs = rs; pif.id_rt = rt; pif.id_useRt = urt; pif.ex_memRead = mr;
    pif.ex_writeDataReg = wr; pif.ex_branchTaken = br;
    pif.ex_mdStart = ms; pif.ex_mdOp = mo;
    x.nm = nm;
    x.v  = e;
    q.push_back(x);
  endtask

  task automatic idle(input logic [9:0] e, input string nm);
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  // Monitor: outputs are presented every cycle, so each pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [9:0] act;
      x   = q.pop_front();
      act = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
             pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.md_busy, pif.md_done};
      total++;
      if (act !== x.v) begin
        bad++;
        $display("FAIL %s: got %b expected %b", x.nm, act, x.v);
      end
    end
  end

  initial begin
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "reset0");
    drv(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, E_RST, "reset_busy_in");
    idle(E_RUN, "run_idle");
    drv(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_LU,  "lu_rs");
    idle(E_RUN, "lu_cleared");
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "lu_r0");
    drv(1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_RUN, "lu_rt_unused");
    drv(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_LU,  "lu_rt");
    drv(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, E_RUN, "no_load");
    drv(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, E_BR,  "br_over_lu");
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_BR,  "br_only");
    idle(E_RUN, "after_br");
`ifdef PIPE_CTRL_MULDIV_EN
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_RUN, "mul_start_br");
    for (int i = 0; i < 4; i++)
      drv(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, E_WAIT, "mul_wait");
    drv(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, E_DONE, "mul_done");
    idle(E_RUN, "mul_back_run");
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, "div_start");
    for (int i = 0; i < 32; i++) idle(E_WAIT, "div_wait");
    idle(E_DONE, "div_done");
    idle(E_RUN, "div_back_run");
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, "div2_start");
    for (int i = 0; i < 9; i++) idle(E_WAIT, "div2_wait");
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "div2_abort");
    for (int i = 0; i < 40; i++) idle(E_RUN, "post_abort_run");
`else
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_RUN, "md_off_mul");
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, "md_off_div");
    for (int i = 0; i < 5; i++) idle(E_RUN, "md_off_idle");
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_BR,  "md_off_br");
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "mid_reset");
    idle(E_RUN, "post_reset_run");
`endif
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "final_r0");
    drv(1'b1, 5'd12, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, E_LU, "final_lu");
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-004 id_useRt  input  1  ID instruction reads rt.
REQ-005 ex_memRead  input  1  EX instruction is a load.
REQ-006 ex_writeDataReg  input  5  destination register of the EX instruction.
REQ-007 ex_branchTaken  input  1  branch/jump resolved taken in EX.
REQ-008 ex_mdStart, ex_mdOp  input  1 each  EX holds a mul (mdOp=0) or div (mdOp=1) op.
REQ-009 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables.
REQ-010 ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (all-zero control) instead of data.
REQ-011 md_busy, md_done  output  1 each  multi-cycle unit running / result valid this cycle.

Function
REQ-012 FSM states: RUN, MD_WAIT, MD_DONE; 6-bit down-counter md_cnt.
REQ-013 Outputs decode combinationally from the current state and inputs; no added latency.
REQ-014 RUN default: all enables 1, all flushes 0, md_busy 0, md_done 0.
REQ-015 Load-use hazard = ex_memRead & ex_writeDataReg!=0 & (ex_writeDataReg==id_rs | (id_useRt & ex_writeDataReg==id_rt)).
REQ-016 Load-use in RUN: pc_en=0, ifid_en=0, idex_flush=1 for exactly the detecting cycle; the hazard then clears because the load advances to MEM.
REQ-017 ex_branchTaken in RUN: ifid_flush=1, idex_flush=1, pc_en=1.
REQ-018 ex_branchTaken and load-use in the same cycle: the branch response wins; no stall is applied.
REQ-019 ex_mdStart in RUN: the next state is MD_WAIT, with md_cnt loaded to 4 (mul) or 32 (div).
REQ-020 ex_mdStart with ex_branchTaken: ex_mdStart wins; ex_branchTaken is ignored.
REQ-021 MD_WAIT: pc_en=ifid_en=idex_en=0, exmem_flush=1, memwb_en=1, md_busy=1.
REQ-022 MD_WAIT: md_cnt decrements each cycle; at md_cnt==1 the next state is MD_DONE.
REQ-023 MD_WAIT: all of ex_mdStart, ex_branchTaken and load-use are ignored.
REQ-024 MD_DONE lasts one cycle: md_done=1, md_busy=0, all enables 1, all flushes 0; the next state is RUN.
REQ-025 MD_DONE: ex_mdStart, ex_branchTaken and load-use are ignored, because the EX instruction is the completing op.
REQ-026 md_cnt never wraps; it holds 0 outside MD_WAIT.

Reset
REQ-027 While rst=0: state=RUN, md_cnt=0.
REQ-028 While rst=0: all enables=0, all flushes=1, md_busy=0, md_done=0.
REQ-029 Assertion of rst mid-MD_WAIT aborts the operation immediately; md_done is not produced.
REQ-030 After rst deasserts, the first rising edge evaluates in RUN.

Configuration
REQ-031 Macro PIPE_CTRL_MULDIV_EN defined: MD_WAIT, MD_DONE and md_cnt are present as specified.
REQ-032 Macro PIPE_CTRL_MULDIV_EN undefined: the FSM is RUN only, ex_mdStart and ex_mdOp are ignored, and md_busy=md_done=0 constantly.

Verification
REQ-033 Load-use: ex_memRead=1, ex_writeDataReg=8, id_rs=8 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then RUN defaults.
REQ-034 Load with ex_writeDataReg=0, id_rs=0 -> no stall; id_useRt=0, id_rt match -> no stall.
REQ-035 ex_branchTaken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1.
REQ-036 Multi-cycle timing:
- mul start -> md_busy=1 for 4 cycles, then md_done=1 for 1 cycle;
- div start -> md_busy=1 for 32 cycles, then md_done=1 for 1 cycle.
REQ-037 rst pulled low at div cycle 10 -> outputs reach reset values immediately; after release, RUN with md_done never asserted.
REQ-038 Build without PIPE_CTRL_MULDIV_EN: ex_mdStart=1 -> md_busy stays 0 and all enables stay 1.
